fb_scanout: RTL and testbench
=============================

Name: fb_scanout

Overview:
Parametrised framebuffer scan-out engine: generates VGA timing, fetches pixels from the read port of the dual-port frame RAM, and drives hsync/vsync/RGB with latency-matched blanking. Replaces the ad-hoc addrB/hcount logic in the top level. Adds configurable timing, colour width, RAM latency, a frame-latched base address (double buffering) and a 2x pixel-replication mode (a 320x240 image fills a 640x480 screen).

Parameters:
H_ACTIVE, 640, visible pixels per line (must be even)
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines (must be even)
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
ADDR_W, 19, RAM address width
CH_W, 4, bits per colour channel; RAM word = 3*CH_W, packed {b,g,r}
RAM_LAT, 1, RAM read latency in pix_ce ticks (1..3)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high
pix_ce  in  1  pixel clock enable (one pulse per pixel, e.g. every 4th clk)
scale  in  1  0 = 1x, 1 = 2x replication; sampled at frame start
base_addr  in  ADDR_W  frame base address; sampled at frame start
rd_addr  out  ADDR_W  RAM port-B address
rd_en  out  1  high while rd_addr is a valid active-area fetch
rd_data  in  3*CH_W  RAM port-B data, valid RAM_LAT ticks after rd_addr
hsync  out  1  active-low
vsync  out  1  active-low
de  out  1  display enable, aligned with r/g/b
r, g, b  out  CH_W each  colour outputs, 0 when de low
frame_start  out  1  one-clk pulse when the stage-0 counters are at (0,0) on a pix_ce tick
vblank  out  1  high while stage-0 vcount >= V_ACTIVE

Behaviour:
- Single clock clk; all state advances only on clk edges where pix_ce=1; pix_ce=0 holds all state (frame_start is 0 on such cycles).
- Stage 0 counters: hcnt 0..H_TOTAL-1, vcnt 0..V_TOTAL-1, where H_TOTAL = sum of the H_* parameters and V_TOTAL likewise. Order per line: active, FP, sync, BP. vcnt increments when hcnt wraps.
- Raw sync: hsync low for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vsync analogous on vcnt.
- Frame start at (0,0): latch scale and base_addr into shadow registers and pulse frame_start. Mid-frame changes to these inputs have no effect until the next frame.
- 1x address: base + vcnt*H_ACTIVE + hcnt, computed incrementally (line_base register plus column counter; no multiplier).
- 2x address: base + (vcnt>>1)*(H_ACTIVE/2) + (hcnt>>1). The address increments every second active pixel; line_base advances by H_ACTIVE/2 after every odd line only.
- Address arithmetic wraps modulo 2^ADDR_W.
- rd_en = 1 iff hcnt < H_ACTIVE and vcnt < V_ACTIVE. rd_addr holds its last value when rd_en = 0.
- Pipeline: de, hsync and vsync are delayed by RAM_LAT+1 pix_ce ticks. Output registers load r = rd_data[CH_W-1:0], g = rd_data[2CH_W-1:CH_W], b = rd_data[3CH_W-1:2CH_W] when delayed de = 1, else 0. Total address-to-pin latency is RAM_LAT+1 ticks for every signal.
- Reset values: counters 0, shadow scale 0, shadow base 0, rd_addr 0, rd_en 0, hsync=vsync=1, de 0, r=g=b 0, frame_start 0, vblank 0, delay lines flushed to inactive.
- Reset mid-frame: all outputs take reset values on the next clk. Scanning restarts at (0,0), and the first pix_ce tick after reset is a frame start.
- Elaboration error if H_ACTIVE or V_ACTIVE is odd, or RAM_LAT is outside 1..3.

Decomposition:
- Package fb_pkg: default 640x480 timing constants, H_TOTAL/V_TOTAL functions, pixel word field offsets.
- Sub-module vga_timing_gen: counters, raw sync, active flags, frame_start. fb_scanout adds address generation, delay lines and the colour register.

Test Plan:
- Default parameters, pix_ce every 4th clk, scale=0, base=0: first frame fetches addresses 0..307199 in order, with rd_en high for exactly 307200 ticks. H_TOTAL=800, V_TOTAL=525. hsync low for 96 ticks starting at hcnt 656; vsync low on lines 490-491.
- RAM model with RAM_LAT=2, data = addr[11:0]: at pixel (3,0), r=3, g=0, b=0, with de high exactly 3 ticks after rd_en, and sync delayed identically.
- scale=1, base=1000: line 0 addresses 1000,1000,1001,1001,...,1319,1319; line 1 repeats line 0; line 2 starts at 1320; last fetch is 1000+76799.
- Change base_addr from 0 to 2000 at vcnt=100: rest of frame continues from base 0; the next frame's first rd_addr is 2000, coincident with the frame_start pulse.
- Assert reset for 1 clk at hcnt=300, vcnt=200: next clk hsync=vsync=1, de=0, rgb=0; the first pix_ce tick after reset produces frame_start=1 and rd_addr=base.
- Hold pix_ce=0 for 50 clks mid-line: all outputs frozen. Resuming continues with the next address and no skipped or duplicated fetch.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared timing defaults, counter sizing helpers and pixel-word layout
// for the framebuffer scan-out engine.
package fb_pkg;

  // Default 640x480 @ 60 Hz timing
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Channel slots inside a RAM word; the word is packed {b,g,r}
  localparam int FIELD_R = 0;
  localparam int FIELD_G = 1;
  localparam int FIELD_B = 2;

  // Control bits that travel down the latency-matching delay line
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } vid_ctl_t;

  localparam vid_ctl_t CTL_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // One spare code so sync-end comparisons never alias back to zero
  function automatic int cnt_width(input int total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: read port B of the dual-port frame RAM.
interface fb_scanout_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_addr, output rd_en, input rd_data);
  modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: stage-0 pixel/line counters with raw sync, active flags and
// the frame-start pulse. Everything advances only on pix_ce ticks.
module vga_timing_gen import fb_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int HW = cnt_width(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  localparam int VW = cnt_width(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_ce,
  output logic [HW-1:0] hcnt,
  output logic          active,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          origin,
  output logic          line_end,
  output logic          odd_line,
  output logic          frame_start,
  output logic          vblank
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [VW-1:0] vcnt;

  // Decode the current counter position into area, sync and origin flags
  always_comb begin
    active   = (hcnt < H_ACT) && (vcnt < V_ACT);
    hs_raw   = !((hcnt >= HS_BEG) && (hcnt < HS_END));
    vs_raw   = !((vcnt >= VS_BEG) && (vcnt < VS_END));
    origin   = (hcnt == '0) && (vcnt == '0);
    line_end = (hcnt == H_LAST);
    odd_line = vcnt[0];
  end

  // Raster counters, frame-start pulse and vblank flag
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      frame_start <= pix_ce & origin;
      if (pix_ce) begin
        vblank <= (vcnt >= V_ACT);
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: VGA scan-out engine. Generates read addresses into the frame RAM
// (1x or 2x replicated, frame-latched base), then delays de/hsync/vsync by the
// RAM latency plus the colour register so every pin lines up with its pixel.
module fb_scanout import fb_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int ADDR_W   = 19,
  parameter int CH_W     = 4,
  parameter int RAM_LAT  = 1,
  localparam int HW = cnt_width(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP))
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic              scale,
  input  logic [ADDR_W-1:0] base_addr,
  fb_scanout_if.master      ram,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [CH_W-1:0]   r,
  output logic [CH_W-1:0]   g,
  output logic [CH_W-1:0]   b,
  output logic              frame_start,
  output logic              vblank
);

  if ((H_ACTIVE % 2) != 0 || (V_ACTIVE % 2) != 0) begin : g_geom_err
    $error("fb_scanout: H_ACTIVE and V_ACTIVE must be even");
  end
  if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_lat_err
    $error("fb_scanout: RAM_LAT must be in 1..3");
  end

  localparam logic [ADDR_W-1:0] STEP_1X = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] STEP_2X = ADDR_W'(H_ACTIVE / 2);

  logic [HW-1:0]     hcnt;
  logic              active, hs_raw, vs_raw, origin, line_end, odd_line;
  logic              scale_r;
  logic [ADDR_W-1:0] line_base_r, addr_r;
  vid_ctl_t          ctl_r;
  vid_ctl_t          dly_r [RAM_LAT];
  logic              scale_cur;
  logic [ADDR_W-1:0] base_cur, col, addr_nxt, line_step;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .hcnt(hcnt), .active(active),
    .hs_raw(hs_raw), .vs_raw(vs_raw), .origin(origin), .line_end(line_end),
    .odd_line(odd_line), .frame_start(frame_start), .vblank(vblank)
  );

  assign ram.rd_addr = addr_r;
  assign ram.rd_en   = ctl_r.de;

  // Address of the current pixel; at the origin the live inputs stand in for
  // the shadows that are being loaded on that same tick
  always_comb begin
    scale_cur = scale_r;
    base_cur  = line_base_r;
    if (origin) begin
      scale_cur = scale;
      base_cur  = base_addr;
    end else begin
      scale_cur = scale_r;
      base_cur  = line_base_r;
    end
    if (scale_cur) col = ADDR_W'(hcnt >> 1);
    else           col = ADDR_W'(hcnt);
    addr_nxt = base_cur + col;
    // In 2x mode each source row is shown twice, so only odd lines advance it
    if (!scale_r)      line_step = STEP_1X;
    else if (odd_line) line_step = STEP_2X;
    else               line_step = '0;
  end

  // Frame shadows, incremental line base, fetch address and stage-1 control
  always_ff @(posedge clk) begin
    if (reset) begin
      scale_r     <= 1'b0;
      line_base_r <= '0;
      addr_r      <= '0;
      ctl_r       <= CTL_IDLE;
    end else if (pix_ce) begin
      if (origin) begin
        scale_r     <= scale;
        line_base_r <= base_addr;
      end else if (line_end) begin
        line_base_r <= line_base_r + line_step;
      end
      if (active) addr_r <= addr_nxt;
      ctl_r <= '{de: active, hs: hs_raw, vs: vs_raw};
    end
  end

  // Delay control by the RAM latency, then register it together with colour
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_LAT; i++) dly_r[i] <= CTL_IDLE;
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else if (pix_ce) begin
      dly_r[0] <= ctl_r;
      for (int i = 1; i < RAM_LAT; i++) dly_r[i] <= dly_r[i-1];
      de    <= dly_r[RAM_LAT-1].de;
      hsync <= dly_r[RAM_LAT-1].hs;
      vsync <= dly_r[RAM_LAT-1].vs;
      if (dly_r[RAM_LAT-1].de) begin
        r <= ram.rd_data[FIELD_R*CH_W +: CH_W];
        g <= ram.rd_data[FIELD_G*CH_W +: CH_W];
        b <= ram.rd_data[FIELD_B*CH_W +: CH_W];
      end else begin
        r <= '0;
        g <= '0;
        b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed bench on a reduced 16x8 raster (24x12 total) with a
// two-tick RAM model whose data equals the address.
module tb_fb_scanout;
  import fb_pkg::*;

  localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 8,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int ADDR_W = 12, CH_W = 4, RAM_LAT = 2;
  localparam int H_TOT = 24, V_TOT = 12, F_TOT = H_TOT * V_TOT;

  logic clk = 1'b0;
  logic reset, pix_ce, scale;
  logic [ADDR_W-1:0] base_addr;
  logic hsync, vsync, de, frame_start, vblank;
  logic [CH_W-1:0] r, g, b;

  int n_pass = 0;
  int n_total = 0;

  fb_scanout_if #(.ADDR_W(ADDR_W), .DATA_W(3*CH_W)) ram ();

  fb_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .ADDR_W(ADDR_W), .CH_W(CH_W), .RAM_LAT(RAM_LAT)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .scale(scale), .base_addr(base_addr),
    .ram(ram), .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
    .frame_start(frame_start), .vblank(vblank)
  );

  always #5 clk = ~clk;

  // RAM model: data = address, valid RAM_LAT pix_ce ticks later
  logic [11:0] ram_q [RAM_LAT];
  always @(posedge clk) begin
    if (pix_ce) begin
      ram_q[0] <= ram.rd_addr;
      for (int i = 1; i < RAM_LAT; i++) ram_q[i] <= ram_q[i-1];
    end
  end
  assign ram.rd_data = ram_q[RAM_LAT-1];

  typedef struct {
    int   n;
    logic fs, en;
    int   addr;
    logic vb, hs, vs, de;
    int   r, g, b;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One pixel tick: three idle clocks then one clock with pix_ce high;
  // returns #1 after the tick edge
  task automatic tick();
    repeat (3) @(posedge clk);
    #1 pix_ce = 1'b1;
    @(posedge clk);
    #1 pix_ce = 1'b0;
  endtask

  // Frame f of the main run: frame 0 base 0 1x, frame 1 base 1000 2x, frame 2 base 4090 1x
  function automatic int frame_base(input int f);
    case (f)
      0:       return 0;
      1:       return 1000;
      default: return 4090;
    endcase
  endfunction

  function automatic logic [11:0] exp_addr(input int n);
    int f, p, h, v, a;
    f = n / F_TOT; p = n % F_TOT; h = p % H_TOT; v = p / H_TOT;
    if (f == 1) a = frame_base(f) + (v / 2) * (H_ACTIVE / 2) + h / 2;
    else        a = frame_base(f) + v * H_ACTIVE + h;
    return a[11:0];
  endfunction

  function automatic logic px_active(input int n);
    int p;
    p = n % F_TOT;
    return ((p % H_TOT) < H_ACTIVE) && ((p / H_TOT) < V_ACTIVE);
  endfunction

  function automatic logic px_hs(input int n);
    int h;
    h = (n % F_TOT) % H_TOT;
    return !(h >= 18 && h < 21);
  endfunction

  function automatic logic px_vs(input int n);
    int v;
    v = (n % F_TOT) / H_TOT;
    return !(v >= 9 && v < 11);
  endfunction

  task automatic check_pixel(input int n, input int hold);
    int p, v, m;
    logic act_m;
    logic [11:0] a;
    p = n % F_TOT; v = p / H_TOT;
    check($sformatf("frame_start@%0d", n), frame_start, (p == 0));
    check($sformatf("rd_en@%0d", n), ram.rd_en, px_active(n));
    check($sformatf("rd_addr@%0d", n), ram.rd_addr, hold);
    check($sformatf("vblank@%0d", n), vblank, (v >= V_ACTIVE));
    if (n >= 3) begin
      m = n - 3;
      act_m = px_active(m);
      a = act_m ? exp_addr(m) : 12'h000;
      check($sformatf("de@%0d", n), de, act_m);
      check($sformatf("hsync@%0d", n), hsync, px_hs(m));
      check($sformatf("vsync@%0d", n), vsync, px_vs(m));
      check($sformatf("r@%0d", n), r, a[3:0]);
      check($sformatf("g@%0d", n), g, a[7:4]);
      check($sformatf("b@%0d", n), b, a[11:8]);
    end else begin
      check($sformatf("de@%0d", n), de, 1'b0);
      check($sformatf("hsync@%0d", n), hsync, 1'b1);
      check($sformatf("vsync@%0d", n), vsync, 1'b1);
      check($sformatf("rgb@%0d", n), {r, g, b}, 12'h000);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rd_addr"}, ram.rd_addr, 12'd0);
    check({tag, "_rd_en"}, ram.rd_en, 1'b0);
    check({tag, "_hsync"}, hsync, 1'b1);
    check({tag, "_vsync"}, vsync, 1'b1);
    check({tag, "_de"}, de, 1'b0);
    check({tag, "_rgb"}, {r, g, b}, 12'h000);
    check({tag, "_frame_start"}, frame_start, 1'b0);
    check({tag, "_vblank"}, vblank, 1'b0);
  endtask

  initial begin
    int idx, hold, en_cnt;
    //           n    fs    en    addr  vb    hs    vs    de    r   g   b
    tbl[0]  = '{0,   1'b1, 1'b1, 0,    1'b0, 1'b1, 1'b1, 1'b0, 0,  0,  0};
    tbl[1]  = '{6,   1'b0, 1'b1, 6,    1'b0, 1'b1, 1'b1, 1'b1, 3,  0,  0};
    tbl[2]  = '{16,  1'b0, 1'b0, 15,   1'b0, 1'b1, 1'b1, 1'b1, 13, 0,  0};
    tbl[3]  = '{21,  1'b0, 1'b0, 15,   1'b0, 1'b0, 1'b1, 1'b0, 0,  0,  0};
    tbl[4]  = '{24,  1'b0, 1'b1, 16,   1'b0, 1'b1, 1'b1, 1'b0, 0,  0,  0};
    tbl[5]  = '{66,  1'b0, 1'b0, 47,   1'b0, 1'b1, 1'b1, 1'b1, 15, 2,  0};
    tbl[6]  = '{192, 1'b0, 1'b0, 127,  1'b1, 1'b1, 1'b1, 1'b0, 0,  0,  0};
    tbl[7]  = '{263, 1'b0, 1'b0, 127,  1'b1, 1'b0, 1'b0, 1'b0, 0,  0,  0};
    tbl[8]  = '{288, 1'b1, 1'b1, 1000, 1'b0, 1'b1, 1'b1, 1'b0, 0,  0,  0};
    tbl[9]  = '{291, 1'b0, 1'b1, 1001, 1'b0, 1'b1, 1'b1, 1'b1, 8,  14, 3};
    tbl[10] = '{317, 1'b0, 1'b1, 1002, 1'b0, 1'b1, 1'b1, 1'b1, 9,  14, 3};
    tbl[11] = '{336, 1'b0, 1'b1, 1008, 1'b0, 1'b1, 1'b1, 1'b0, 0,  0,  0};
    tbl[12] = '{471, 1'b0, 1'b1, 1031, 1'b0, 1'b1, 1'b1, 1'b1, 6,  0,  4};
    tbl[13] = '{576, 1'b1, 1'b1, 4090, 1'b0, 1'b1, 1'b1, 1'b0, 0,  0,  0};
    tbl[14] = '{586, 1'b0, 1'b1, 4,    1'b0, 1'b1, 1'b1, 1'b1, 1,  0,  0};

    reset = 1'b1; pix_ce = 1'b0; scale = 1'b0; base_addr = 12'd0;
    repeat (3) @(posedge clk);
    #1 pix_ce = 1'b1;
    @(posedge clk);
    #1 pix_ce = 1'b0;
    check_reset_state("reset");
    reset = 1'b0;

    // Three frames: 1x base 0, 2x base 1000, 1x base 4090 (address wrap)
    idx = 0; hold = 0; en_cnt = 0;
    for (int n = 0; n < 3 * F_TOT; n++) begin
      if (n == 100) begin scale = 1'b1; base_addr = 12'd1000; end
      if (n == 400) begin scale = 1'b0; base_addr = 12'd4090; end
      tick();
      if (px_active(n)) hold = exp_addr(n);
      check_pixel(n, hold);
      if (ram.rd_en) en_cnt++;
      if ((n % F_TOT) == F_TOT - 1) begin
        check($sformatf("fetch_count_f%0d", n / F_TOT), en_cnt, 128);
        en_cnt = 0;
      end
      if (idx < 15 && tbl[idx].n == n) begin
        check($sformatf("tbl%0d_fs", idx), frame_start, tbl[idx].fs);
        check($sformatf("tbl%0d_en", idx), ram.rd_en, tbl[idx].en);
        check($sformatf("tbl%0d_addr", idx), ram.rd_addr, tbl[idx].addr);
        check($sformatf("tbl%0d_vblank", idx), vblank, tbl[idx].vb);
        check($sformatf("tbl%0d_hsync", idx), hsync, tbl[idx].hs);
        check($sformatf("tbl%0d_vsync", idx), vsync, tbl[idx].vs);
        check($sformatf("tbl%0d_de", idx), de, tbl[idx].de);
        check($sformatf("tbl%0d_r", idx), r, tbl[idx].r);
        check($sformatf("tbl%0d_g", idx), g, tbl[idx].g);
        check($sformatf("tbl%0d_b", idx), b, tbl[idx].b);
        idx++;
      end
      // Stall mid-line: nothing may move while pix_ce stays low
      if (n == 150) begin
        repeat (50) @(posedge clk);
        #1;
        check_pixel(n, hold);
      end
    end
    check("table_consumed", idx, 15);

    // Reset in the middle of an active line, then restart from the origin
    base_addr = 12'd77; scale = 1'b0;
    repeat (132) tick();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state("midreset");
    tick();
    check("post_reset_fs", frame_start, 1'b1);
    check("post_reset_addr", ram.rd_addr, 12'd77);
    check("post_reset_en", ram.rd_en, 1'b1);
    tick();
    check("post_reset_addr1", ram.rd_addr, 12'd78);
    check("post_reset_fs1", frame_start, 1'b0);
    tick();
    check("post_reset_de2", de, 1'b0);
    tick();
    check("post_reset_de3", de, 1'b1);
    check("post_reset_r", r, 4'hD);
    check("post_reset_g", g, 4'h4);
    check("post_reset_b", b, 4'h0);
    check("post_reset_hsync", hsync, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
